mul_share_ctrl: RTL and testbench

Round-robin controller that shares one variable-latency shift-and-add multiplier between `NREQ` requesters. It grants one request at a time, launches it on the multiplier, and waits for the multiplier's `out_valid`. It then returns the tagged product on a held response channel. The block sits between the requesting engines and the single multiplier instance and is the only driver of the multiplier's `in_valid`, `a` and `b`.

---
 rtl/mul_share_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one variable-latency multiplier between NREQ requesters.
// Every output is a register; a grant (req_ready pulse) is only ever visible while in IDLE.
module mul_share_ctrl #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    parameter  int TMO   = WIDTH + 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  mul_in_valid,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_o,
    input  logic                  mul_out_valid,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [2*WIDTH-1:0]    resp_o,
    output logic                  resp_err
);

    localparam int            CW      = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_TMO = CW'(TMO - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t               state, state_d;
    logic [IDW-1:0]       last, last_d;
    logic [IDW-1:0]       gnt_idx, cand;
    logic                 gnt_found, arb_en;
    logic [CW-1:0]        cnt, cnt_d;
    logic                 pend, pend_d;
    logic [NREQ-1:0]      req_ready_d;
    logic                 mul_in_valid_d;
    logic [WIDTH-1:0]     mul_a_d, mul_b_d;
    logic                 resp_valid_d;
    logic [IDW-1:0]       resp_id_d;
    logic [2*WIDTH-1:0]   resp_o_d;
    logic                 resp_err_d;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k >= NREQ) ? IDW'(int'(last) + k - NREQ) : IDW'(int'(last) + k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Arbitration runs in the cycle whose successor is IDLE, so req_ready lands in IDLE itself.
    always_comb begin
        state_d        = state;
        last_d         = last;
        cnt_d          = cnt;
        pend_d         = pend;
        req_ready_d    = '0;
        mul_in_valid_d = 1'b0;
        mul_a_d        = mul_a;
        mul_b_d        = mul_b;
        resp_valid_d   = resp_valid;
        resp_id_d      = resp_id;
        resp_o_d       = resp_o;
        resp_err_d     = resp_err;
        arb_en         = 1'b0;

        case (state)
            S_FLUSH: begin
                if (mul_out_valid || cnt == CNT_TMO) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            S_IDLE: begin
                if (|req_ready) begin
                    if (mul_a == '0 || mul_b == '0) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_o_d     = '0;
                        resp_err_d   = 1'b0;
                    end else begin
                        state_d        = S_ISSUE;
                        mul_in_valid_d = 1'b1;
                    end
                end else begin
                    arb_en = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (mul_out_valid) begin
                    state_d    = S_DRAIN;
                    cnt_d      = '0;
                    pend_d     = 1'b1;
                    resp_o_d   = mul_o;
                    resp_err_d = 1'b0;
                end else if (cnt == CNT_TMO) begin
                    state_d    = S_DRAIN;
                    cnt_d      = '0;
                    pend_d     = 1'b1;
                    resp_o_d   = '0;
                    resp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_ONE) begin
                    if (pend) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        arb_en  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    arb_en       = 1'b1;
                end
            end
            default: state_d = S_FLUSH;
        endcase

        if (arb_en && gnt_found) begin
            req_ready_d[gnt_idx] = 1'b1;
            mul_a_d              = req_a[gnt_idx*WIDTH +: WIDTH];
            mul_b_d              = req_b[gnt_idx*WIDTH +: WIDTH];
            last_d               = gnt_idx;
            resp_id_d            = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FLUSH;
            last         <= IDW'(NREQ - 1);
            cnt          <= '0;
            pend         <= 1'b0;
            req_ready    <= '0;
            mul_in_valid <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_o       <= '0;
            resp_err     <= 1'b0;
        end else begin
            state        <= state_d;
            last         <= last_d;
            cnt          <= cnt_d;
            pend         <= pend_d;
            req_ready    <= req_ready_d;
            mul_in_valid <= mul_in_valid_d;
            mul_a        <= mul_a_d;
            mul_b        <= mul_b_d;
            resp_valid   <= resp_valid_d;
            resp_id      <= resp_id_d;
            resp_o       <= resp_o_d;
            resp_err     <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: table-driven transactions, hand-written corner sequences and a
// randomized phase scored against a round-robin/product reference model.
module tb_mul_share_ctrl;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int TMO   = WIDTH + 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  mul_in_valid;
    logic [WIDTH-1:0]      mul_a, mul_b;
    logic [2*WIDTH-1:0]    mul_o;
    logic                  mul_out_valid;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [1:0]            resp_id;
    logic [2*WIDTH-1:0]    resp_o;
    logic                  resp_err;

    mul_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o(mul_o), .mul_out_valid(mul_out_valid),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_o(resp_o), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shift-and-add multiplier stand-in: no reset, programmable latency, finish flag held 2 cycles.
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_prod = '0;
    int          m_left = 0, m_ovn = 0, m_lat = 4;
    bit          m_busy = 1'b0, m_hang = 1'b0;

    always @(posedge clk) begin
        if (m_ovn != 0) m_ovn <= m_ovn - 1;
        if (mul_in_valid && !m_hang) begin
            m_a    <= mul_a;
            m_b    <= mul_b;
            m_left <= m_lat;
            m_busy <= 1'b1;
        end else if (m_busy) begin
            if (m_left <= 1) begin
                m_busy <= 1'b0;
                m_ovn  <= 2;
                m_prod <= 64'(m_a) * 64'(m_b);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end
    assign mul_out_valid = (m_ovn != 0);
    assign mul_o         = m_prod;

    int   ov_cyc  = -1;
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (mul_out_valid && !ov_prev) ov_cyc = cyc;
        ov_prev = mul_out_valid;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    function automatic int ohidx(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int last);
        int j;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i]            = 1'b1;
    endtask

    task automatic wait_grant(output int g, output int t, output bit ok);
        ok = 1'b0; g = -1; t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1; g = ohidx(req_ready); t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_resp(output int t, output bit ok, output int nin, output int tin);
        ok = 1'b0; t = -1; nin = 0; tin = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mul_in_valid) begin nin++; tin = cyc; end
            if (resp_valid) begin ok = 1'b1; t = cyc; break; end
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chki("resp_drop_after_accept", int'(resp_valid), 0);
    endtask

    task automatic run_txn(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] p, input bit err);
        int g, t, tr, nin, tin;
        bit ok;
        @(negedge clk);
        set_req(id, a, b);
        wait_grant(g, t, ok);
        req_valid[id] = 1'b0;
        chki("grant_seen", int'(ok), 1);
        if (!ok) return;
        chki("grant_onehot", int'(req_ready), 1 << id);
        wait_resp(tr, ok, nin, tin);
        chki("resp_seen", int'(ok), 1);
        if (!ok) return;
        if (a == 0 || b == 0) begin
            chki("bypass_no_launch", nin, 0);
            chki("bypass_latency", tr, t + 1);
        end else begin
            chki("launch_count", nin, 1);
            chki("launch_latency", tin, t + 1);
            if (err) chki("watchdog_latency", tr, t + TMO + 4);
            else     chki("finish_latency", tr, ov_cyc + 3);
        end
        chki("resp_id", int'(resp_id), id);
        chk("resp_o", resp_o, p);
        chki("resp_err", int'(resp_err), int'(err));
        accept();
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int g, t, tr, nin, tin, stale, pg, nresp, eid, mlast;
        int rr_exp[5];
        bit ok, rseen;
        logic [3:0]  rv;
        logic [31:0] ea, eb;
        logic [63:0] ep;
        logic [31:0] ra[NREQ], rb[NREQ];

        tbl[0] = '{0, 32'd3,          32'd5,          64'd15};
        tbl[1] = '{1, 32'hDEAD_BEEF,  32'd0,          64'd0};
        tbl[2] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        tbl[3] = '{3, 32'd7,          32'd6,          64'd42};
        tbl[4] = '{2, 32'h8000_0000,  32'd2,          64'h1_0000_0000};
        tbl[5] = '{1, 32'd1,          32'hFFFF_FFFF,  64'hFFFF_FFFF};
        tbl[6] = '{0, 32'd0,          32'd0,          64'd0};
        rr_exp = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (3) @(negedge clk);
        chki("rst_req_ready", int'(req_ready), 0);
        chki("rst_mul_in_valid", int'(mul_in_valid), 0);
        chk("rst_mul_a", {32'b0, mul_a}, 64'd0);
        chk("rst_mul_b", {32'b0, mul_b}, 64'd0);
        chki("rst_resp_valid", int'(resp_valid), 0);
        chki("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_o", resp_o, 64'd0);
        chki("rst_resp_err", int'(resp_err), 0);
        rst = 1'b0;

        // Round-robin with all four requesters held valid
        m_lat = 3;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd2);
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                wait_grant(g, t, ok);
                chki("rr_first_grant_seen", int'(ok), 1);
            end
            chki("rr_grant", int'(req_ready), 1 << rr_exp[k]);
            wait_resp(tr, ok, nin, tin);
            chki("rr_resp_seen", int'(ok), 1);
            chki("rr_resp_id", int'(resp_id), rr_exp[k]);
            chk("rr_resp_o", resp_o, 64'(2 * (rr_exp[k] + 1)));
            if (k == 4) req_valid = '0;
            accept();
        end

        // Table of single transactions
        for (int i = 0; i < 7; i++) begin
            m_lat = 1 + 5 * i;
            run_txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, 1'b0);
        end

        // Backpressure: response held 10 cycles while another requester waits
        m_lat = 6;
        @(negedge clk);
        set_req(0, 32'd11, 32'd13);
        wait_grant(g, t, ok);
        req_valid[0] = 1'b0;
        chki("bp_grant", g, 0);
        set_req(3, 32'd2, 32'd2);
        wait_resp(tr, ok, nin, tin);
        chki("bp_resp_seen", int'(ok), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chki("bp_hold_valid", int'(resp_valid), 1);
            chki("bp_hold_id", int'(resp_id), 0);
            chk("bp_hold_o", resp_o, 64'd143);
            chki("bp_no_grant", int'(req_ready), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chki("bp_next_grant_r_plus_1", int'(req_ready), 4'b1000);
        req_valid[3] = 1'b0;
        wait_resp(tr, ok, nin, tin);
        chki("bp_second_id", int'(resp_id), 3);
        chk("bp_second_o", resp_o, 64'd4);
        accept();

        // Watchdog, then a normal transaction
        m_hang = 1'b1;
        run_txn(1, 32'd9, 32'd9, 64'd0, 1'b1);
        m_hang = 1'b0;
        m_lat  = 5;
        run_txn(2, 32'd5, 32'd5, 64'd25, 1'b0);

        // Reset in the middle of WAIT
        m_lat = 20;
        @(negedge clk);
        set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_grant(g, t, ok);
        req_valid[1] = 1'b0;
        chki("mid_grant", g, 1);
        for (int i = 0; i < 20 && !mul_in_valid; i++) @(negedge clk);
        chki("mid_launch_seen", int'(mul_in_valid), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chki("mid_rst_resp_valid", int'(resp_valid), 0);
        chki("mid_rst_req_ready", int'(req_ready), 0);
        chki("mid_rst_in_valid", int'(mul_in_valid), 0);
        chk("mid_rst_mul_a", {32'b0, mul_a}, 64'd0);
        chk("mid_rst_resp_o", resp_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_lat = 3;
        set_req(2, 32'd7, 32'd6);
        stale = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_valid) stale++;
            if (req_ready != '0) begin ok = 1'b1; g = ohidx(req_ready); t = cyc; break; end
        end
        req_valid[2] = 1'b0;
        chki("mid_post_grant_seen", int'(ok), 1);
        chki("mid_no_stale_resp", stale, 0);
        chki("mid_post_grant_id", g, 2);
        chki("mid_flush_to_grant", t, ov_cyc + 3);
        wait_resp(tr, ok, nin, tin);
        chki("mid_post_resp_seen", int'(ok), 1);
        chki("mid_post_resp_id", int'(resp_id), 2);
        chk("mid_post_resp_o", resp_o, 64'd42);
        chki("mid_post_resp_err", int'(resp_err), 0);
        accept();

        // Randomized traffic against the reference model
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        mlast = NREQ - 1;
        nresp = 0; rseen = 1'b0;
        ea = '0; eb = '0; ep = '0; eid = 0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
        for (int c = 0; c < 8000 && nresp < 60; c++) begin
            @(negedge clk);
            rv = req_valid;
            if (req_ready != '0) begin
                pg = rr_pick(rv, mlast);
                chki("rnd_grant", int'(req_ready), (pg < 0) ? 0 : (1 << pg));
                if (pg >= 0) begin
                    mlast = pg; eid = pg;
                    ea = ra[pg]; eb = rb[pg];
                    ep = 64'(ea) * 64'(eb);
                    req_valid[pg] = 1'b0;
                end
            end
            if (mul_in_valid) begin
                chk("rnd_mul_a", {32'b0, mul_a}, {32'b0, ea});
                chk("rnd_mul_b", {32'b0, mul_b}, {32'b0, eb});
            end
            if (resp_valid && !rseen) begin
                chki("rnd_resp_id", int'(resp_id), eid);
                chk("rnd_resp_o", resp_o, ep);
                chki("rnd_resp_err", int'(resp_err), 0);
                rseen = 1'b1;
            end
            if (resp_valid && resp_ready) begin
                nresp++;
                rseen = 1'b0;
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    ra[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    rb[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    set_req(i, ra[i], rb[i]);
                end
            end
            m_lat = $urandom_range(1, 20);
        end
        chki("rnd_all_responses", nresp, 60);
        req_valid  = '0;
        resp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
